mmc3_scanline_irq: RTL
======================

// Module: mmc3_scanline_irq
// PURPOSE
//  Synchronous MMC3-style scanline IRQ unit, clocked by CPU M2.
//  - Filters PPU A12 into one scanline tick per qualified rising edge.
//  - Runs the 8-bit reload/decrement counter and drives the mapper /IRQ.
//  - Consumes the $C000-$FFFF register writes decoded by the mapper bank/register stage.
// PARAMETERS
//  A12_LOW_CYCLES  3  consecutive M2 cycles A12 must be low before a rise counts
//  SYNC_STAGES     2  flops in the ppu_a12 synchronizer (>=2)
//  CNT_W           8  counter/latch width
// PORTS
//  m2          in   1      CPU M2; all state changes on rising edge
//  rst_n       in   1      async active-low reset
//  ppu_a12     in   1      raw PPU address bit 12, asynchronous to m2
//  wr_en       in   1      one-cycle write strobe from register decoder
//  wr_reg      in   2      0=$C000 latch, 1=$C001 reload, 2=$E000 disable, 3=$E001 enable
//  wr_data     in   CNT_W  write data; used only for wr_reg=0
//  irq_n       out  1      registered active-low IRQ; top level converts to open-drain
//  scan_tick   out  1      qualified A12 tick, one cycle, for debug/LED
//  irq_count   out  CNT_W  current counter value, for debug
// BEHAVIOUR
//  Reset: counter=0, latch=0, reload_pend=0, irq_en=0, irq_pend=0.
//   Reset: irq_n=1, low_cnt=0, synchronizer=0, scan_tick=0.
//  A12 filter:
//   - a12_s = last synchronizer stage.
//   - low_cnt counts cycles with a12_s=0, saturating at A12_LOW_CYCLES; cleared when a12_s=1.
//   - scan_tick = a12_s & ~a12_s_prev & (low_cnt==A12_LOW_CYCLES), combinational, one cycle.
//   - A rise after a shorter low period is ignored entirely; no tick and no state change.
//  Counter, evaluated on scan_tick:
//   - If counter==0 or reload_pend: counter<=latch, reload_pend<=0.
//   - Otherwise counter<=counter-1.
//   - If the resulting value is 0 and irq_en=1: irq_pend<=1.
//  Writes (wr_en=1):
//   - 0: latch<=wr_data.
//   - 1: counter<=0, reload_pend<=1.
//   - 2: irq_en<=0, irq_pend<=0 (acknowledge).
//   - 3: irq_en<=1; does not set irq_pend by itself.
//  Simultaneous write and tick in the same cycle:
//   - The tick is computed from pre-write state (old latch, old counter).
//   - Write effects then override the fields they touch.
//   - Reload write wins over the tick result. Disable wins over a same-cycle irq_pend set.
//  irq_n = ~irq_pend, registered; stays low until a disable write or reset.
//  Latency: ppu_a12 rise sampled at edge k -> scan_tick during the cycle after edge k+SYNC_STAGES-1.
//   irq_n falls at edge k+SYNC_STAGES (3 edges total with default SYNC_STAGES=2).
//  Counter arithmetic is modulo 2^CNT_W; decrement from 0 never occurs (0 forces reload).
//  latch=0: every tick reloads 0 and re-asserts irq_pend when enabled.
//  Async reset mid-scanline: all state cleared; the first rise after reset needs a full low period.
// CONFIGURATION
//  IRQ_REV_A_EN defined:
//   - Rev-A semantics: irq_pend is set only when the tick decremented a nonzero counter to 0,
//     or when reload_pend was set and latch==0.
//   - Auto-reload of 0 from counter==0 does not re-assert.
//  Undefined (default): Rev-B semantics exactly as described in BEHAVIOUR.
// STRUCTURE
//  mmc3_pkg: wr_reg codes (REG_IRQ_LATCH/RELOAD/DISABLE/ENABLE), CNT_W default.
//  Sub-module a12_filter: synchronizer, low_cnt and edge qualification.
//   Outputs scan_tick; parameterised by A12_LOW_CYCLES and SYNC_STAGES.
//  Top level: latch, counter, reload_pend, irq_en, irq_pend regs and write decode.
// TESTING
//  1 latch=3, reload, enable; 4 qualified A12 rises (low>=4 cycles each):
//    counter 3,2,1,0; irq_n low after 4th rise +3 edges.
//  2 After test 1, write disable: irq_n high next edge. Enable, then 4 more ticks: irq_n low again.
//  3 A12 low only 2 cycles before rise: no tick, counter unchanged.
//    Low 3 cycles: tick occurs. A 1-cycle glitch high then low: no tick.
//  4 Reload write in same cycle as tick, counter=5, latch=9:
//    counter=0 and reload_pend=1 after; next tick loads 9.
//  5 latch=0, enabled, 3 ticks:
//    Rev-B: irq_pend set on each tick.
//    IRQ_REV_A_EN: only the first tick after reload sets it.
//  6 Assert rst_n low mid-count (counter=7, irq_n low):
//    immediately irq_n=1, counter=0; first rise after release is ignored until low_cnt saturates.

Source files
------------

// File: rtl/mmc3_pkg.sv
// Shared definitions for the MMC3 scanline IRQ unit: register-write codes and default widths.
package mmc3_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    REG_IRQ_LATCH   = 2'd0,
    REG_IRQ_RELOAD  = 2'd1,
    REG_IRQ_DISABLE = 2'd2,
    REG_IRQ_ENABLE  = 2'd3
  } wr_reg_e;

endpackage

// File: rtl/mmc3_scanline_irq_a12_filter.sv
// PPU A12 qualifier: synchronizes the raw A12 into the M2 domain and emits one scan_tick per
// rising edge that follows at least A12_LOW_CYCLES synchronized low cycles.
module a12_filter #(
  parameter int A12_LOW_CYCLES = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a12_raw,
  output logic scan_tick
);

  localparam int LW = $clog2(A12_LOW_CYCLES + 1);
  localparam logic [LW-1:0] LOW_MAX = LW'(A12_LOW_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   a12_prev_q, a12_prev_d;
  logic [LW-1:0]          low_cnt_q, low_cnt_d;
  logic                   a12_s;

  assign a12_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], a12_raw};
    a12_prev_d = a12_s;
    low_cnt_d  = low_cnt_q;
    if (a12_s) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LOW_MAX) begin
      low_cnt_d = low_cnt_q + LW'(1);
    end
  end

  // A rise that ends a short low period never ticks, regardless of how long it stays high.
  assign scan_tick = a12_s & ~a12_prev_q & (low_cnt_q == LOW_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      a12_prev_q <= 1'b0;
      low_cnt_q  <= '0;
    end else begin
      sync_q     <= sync_d;
      a12_prev_q <= a12_prev_d;
      low_cnt_q  <= low_cnt_d;
    end
  end

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3 scanline IRQ: A12-qualified tick drives an 8-bit reload/decrement counter and /IRQ.
// Define IRQ_REV_A_EN for Rev-A IRQ assertion semantics; default build is Rev-B.
module mmc3_scanline_irq #(
  parameter int A12_LOW_CYCLES = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = mmc3_pkg::CNT_W_DEF
) (
  input  logic             m2,
  input  logic             rst_n,
  input  logic             ppu_a12,
  input  logic             wr_en,
  input  logic [1:0]       wr_reg,
  input  logic [CNT_W-1:0] wr_data,
  output logic             irq_n,
  output logic             scan_tick,
  output logic [CNT_W-1:0] irq_count
);

  import mmc3_pkg::*;

  // Write interface: wr_en is a single-cycle strobe with no ready; the unit accepts one write
  // every cycle it is asserted, and wr_reg/wr_data are only meaningful while wr_en=1.

  logic [CNT_W-1:0] latch_q, latch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reload_q, reload_d;
  logic             en_q, en_d;
  logic             irq_n_q, irq_n_d;
  logic [CNT_W-1:0] cnt_next;
  logic             irq_set;

  a12_filter #(
    .A12_LOW_CYCLES (A12_LOW_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_a12_filter (
    .clk       (m2),
    .rst_n     (rst_n),
    .a12_raw   (ppu_a12),
    .scan_tick (scan_tick)
  );

  always_comb begin
    cnt_next = cnt_q - CNT_W'(1);
    if ((cnt_q == '0) || reload_q) begin
      cnt_next = latch_q;
    end
`ifdef IRQ_REV_A_EN
    irq_set = en_q && ((reload_q && (latch_q == '0)) || (!reload_q && (cnt_q == CNT_W'(1))));
`else
    irq_set = en_q && (cnt_next == '0);
`endif
  end

  // Tick result is computed from pre-write state; any same-cycle write then overrides its fields.
  always_comb begin
    latch_d  = latch_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    en_d     = en_q;
    irq_n_d  = irq_n_q;
    if (scan_tick) begin
      cnt_d    = cnt_next;
      reload_d = 1'b0;
      if (irq_set) begin
        irq_n_d = 1'b0;
      end
    end
    if (wr_en) begin
      case (wr_reg_e'(wr_reg))
        REG_IRQ_LATCH: latch_d = wr_data;
        REG_IRQ_RELOAD: begin
          cnt_d    = '0;
          reload_d = 1'b1;
        end
        REG_IRQ_DISABLE: begin
          en_d    = 1'b0;
          irq_n_d = 1'b1;
        end
        REG_IRQ_ENABLE: en_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      latch_q  <= '0;
      cnt_q    <= '0;
      reload_q <= 1'b0;
      en_q     <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      latch_q  <= latch_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      irq_n_q  <= irq_n_d;
    end
  end

  assign irq_n     = irq_n_q;
  assign irq_count = cnt_q;

endmodule
